id_ex_stage: RTL

- ID/EX pipeline register that sits directly downstream of the main decode controller in the five-stage RISC-V core.
- Captures the 11-bit control bundle and decode operands each cycle.
- Detects load-use hazards and inserts one-cycle bubbles.
- Honours branch/jump flushes from EX and whole-pipe holds from the memory side.
- Exposes bubble/flush statistics counters.

---
 rtl/pipe_pkg.sv | 42 ++++
 rtl/sat_counter.sv | 25 ++
 rtl/id_ex_stage.sv | 128 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and encodings for the ID/EX pipeline register slice.
// Holds the control bundle layout, the ALUOp/RWSel codes, the stage FSM states and the load-use check.
package pipe_pkg;

  typedef struct packed {
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic [1:0] aluop;
    logic       branch;
    logic       jalrsel;
    logic [1:0] rwsel;
  } ctrl_t;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_RI  = 2'b10;
  localparam logic [1:0] ALUOP_JL  = 2'b11;

  localparam logic [1:0] RW_ALU    = 2'b00;
  localparam logic [1:0] RW_PC4    = 2'b01;
  localparam logic [1:0] RW_IMM    = 2'b10;
  localparam logic [1:0] RW_PCIMM  = 2'b11;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LU_WAIT = 2'd1,
    HOLD_ST = 2'd2
  } stage_state_t;

  // A load in EX whose destination feeds either source of the instruction in ID.
  function automatic logic load_use(input logic       ex_valid,
                                    input logic       ex_memread,
                                    input logic [4:0] ex_rd,
                                    input logic [4:0] rs1,
                                    input logic [4:0] rs2);
    return ex_valid & ex_memread & (ex_rd != 5'd0) & ((ex_rd == rs1) | (ex_rd == rs2));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Count events, sticking at the maximum value.
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= {CNT_W{1'b0}};
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_ONE;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, EX flush, memory-side hold
// and saturating bubble/flush statistics.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  ctrl_t            id_ctrl,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rd1,
  input  logic [XLEN-1:0]  id_rd2,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [2:0]       id_funct3,
  input  logic [6:0]       id_funct7,
  input  logic             flush,
  input  logic             hold,
  output ctrl_t            ex_ctrl,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rd1,
  output logic [XLEN-1:0]  ex_rd2,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [2:0]       ex_funct3,
  output logic [6:0]       ex_funct7,
  output logic             ex_valid,
  output logic             stall_if,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  stage_state_t state_r;
  stage_state_t ret_state_r;
  stage_state_t cur_state_s;
  stage_state_t next_state_s;
  logic         flush_pending_r;
  logic         flush_eff_s;
  logic         lu_s;
  logic         bubble_inc_s;
  logic         flush_inc_s;

  // Hazard detection, stall request and next-state selection.
  always_comb begin
    flush_eff_s  = flush | flush_pending_r;
    lu_s         = load_use(ex_valid, ex_ctrl.memread, ex_rd, id_rs1, id_rs2);
    stall_if     = hold | (~flush_eff_s & lu_s);
    bubble_inc_s = ~hold & ~flush_eff_s & lu_s;
    flush_inc_s  = ~hold & flush_eff_s;
    // Leaving a hold resumes whatever state was interrupted.
    cur_state_s  = (state_r == HOLD_ST) ? ret_state_r : state_r;
    next_state_s = RUN;
    case (cur_state_s)
      RUN:     next_state_s = (!flush_eff_s && lu_s) ? LU_WAIT : RUN;
      LU_WAIT: next_state_s = RUN;
      default: next_state_s = RUN;
    endcase
  end

  // Pipeline register, pending-flush latch and FSM state.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_ctrl         <= '0;
      ex_pc           <= '0;
      ex_rd1          <= '0;
      ex_rd2          <= '0;
      ex_imm          <= '0;
      ex_rs1          <= 5'd0;
      ex_rs2          <= 5'd0;
      ex_rd           <= 5'd0;
      ex_funct3       <= 3'd0;
      ex_funct7       <= 7'd0;
      ex_valid        <= 1'b0;
      flush_pending_r <= 1'b0;
      state_r         <= RUN;
      ret_state_r     <= RUN;
    end else if (hold) begin
      if (flush) begin
        flush_pending_r <= 1'b1;
      end
      if (state_r != HOLD_ST) begin
        ret_state_r <= state_r;
      end
      state_r <= HOLD_ST;
    end else begin
      // Data fields follow ID even for bubbles; ctrl=0 keeps them harmless.
      ex_pc           <= id_pc;
      ex_rd1          <= id_rd1;
      ex_rd2          <= id_rd2;
      ex_imm          <= id_imm;
      ex_rs1          <= id_rs1;
      ex_rs2          <= id_rs2;
      ex_rd           <= id_rd;
      ex_funct3       <= id_funct3;
      ex_funct7       <= id_funct7;
      flush_pending_r <= 1'b0;
      state_r         <= next_state_s;
      if (flush_eff_s || lu_s) begin
        ex_ctrl  <= '0;
        ex_valid <= 1'b0;
      end else begin
        ex_ctrl  <= id_ctrl;
        ex_valid <= 1'b1;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (bubble_inc_s),
    .count (bubble_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (flush_inc_s),
    .count (flush_cnt)
  );

endmodule
